// File: rtl/alu_pkg.sv
// Purpose: shared constants, opcode and FSM encodings for the alu and its request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OPND_W = 4;   // alu operand width
  localparam int OPC_W  = 3;   // alu opcode width
  localparam int RES_W  = 5;   // alu result width (operand width plus carry)

  typedef enum logic [OPC_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Purpose: 4-bit combinational alu, 5-bit result carrying the carry/borrow out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b operands; op opcode (alu_op_t); result 5-bit.
// SUB yields the 5-bit two's-complement difference, so a borrow sets bit 4.
// NOT inverts a only; SHL/SHR shift a by one place (SHL keeps the bit shifted out).
module alu
  import alu_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [OPC_W-1:0]  op,
  output logic [RES_W-1:0]  result
);

  always_comb begin
    result = '0;
    case (alu_op_t'(op))
      OP_ADD:  result = {1'b0, a} + {1'b0, b};
      OP_SUB:  result = {1'b0, a} - {1'b0, b};
      OP_AND:  result = {1'b0, a & b};
      OP_OR:   result = {1'b0, a | b};
      OP_XOR:  result = {1'b0, a ^ b};
      OP_NOT:  result = {1'b0, ~a};
      OP_SHL:  result = {a, 1'b0};
      OP_SHR:  result = {2'b00, a[OPND_W-1:1]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Purpose: combinational 2-way round-robin grant; the last-grant pointer lives in the parent.
// Latency: purely combinational.
// Backpressure: none; grant_vld simply follows the OR of the valids.
// Ports: valid[1:0] requests, last_grant previous winner, grant_vld any request, grant winner index.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_vld,
  output logic       grant
);

  always_comb begin
    grant_vld = |valid;
    grant     = 1'b0;
    if (valid == 2'b11) begin
      // Contention: the requester that did not win last time goes next.
      grant = ~last_grant;
    end else begin
      // Zero or one requester: valid[1] alone selects 1, everything else 0.
      grant = valid[1];
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Purpose: share one alu between two requesters with round-robin arbitration and registered result.
// Latency: result valid on the second edge after the cycle a request is presented and accepted; issue every 3 cycles at best.
// Backpressure: no request is accepted while a response is outstanding; the response is held until rsp_ready.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester command handshake (bit i = requester i)
//   req_a, req_b, req_op    packed per-requester operands/opcodes
//   rsp_valid/rsp_ready     response handshake; rsp_data alu result, rsp_id issuing requester
//   busy                    high whenever an operation is in flight
//   op_count                completed responses, wraps silently
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,   // only 2 is supported
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [OPND_W*NUM_REQ-1:0] req_a,
  input  logic [OPND_W*NUM_REQ-1:0] req_b,
  input  logic [OPC_W*NUM_REQ-1:0]  req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  state_t              state;
  state_t              state_nxt;
  logic                last_grant;
  logic                grant_vld;
  logic                grant;
  logic                accept;
  logic [OPND_W-1:0]   a_q;
  logic [OPND_W-1:0]   b_q;
  logic [OPC_W-1:0]    op_q;
  logic                id_q;
  logic [RES_W-1:0]    alu_res;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant      (grant)
  );

  // The alu only ever sees the captured registers, never the live request bus.
  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          // The arbiter only grants a valid requester, so ready implies a transfer.
          req_ready = NUM_REQ'(1) << grant;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;   // makes requester 0 win the first tie
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        a_q        <= req_a[OPND_W*int'(grant) +: OPND_W];
        b_q        <= req_b[OPND_W*int'(grant) +: OPND_W];
        op_q       <= req_op[OPC_W*int'(grant) +: OPC_W];
        id_q       <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_res;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + CNT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Purpose: self-checking bench for alu_req_arbiter against a transaction-level reference model.
// Latency: n/a.
// Backpressure: exercised through rsp_ready patterns.
module tb_alu_req_arbiter;

  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [5:0] req_op = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_data;
  logic       rsp_id;
  logic       busy;
  logic [CNT_W-1:0] op_count;

  alu_req_arbiter #(.NUM_REQ(2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one transaction in flight at most, results queued in issue order.
  bit m_inflight;
  int m_age;       // edges since the accepting edge
  bit m_last;      // last winner
  int m_count;
  int m_acc;       // requester accepted at the most recent edge, -1 if none
  int q_data[$];
  int q_id[$];

  function automatic int alu_ref(int a, int b, int op);
    case (op)
      0: return (a + b) % 32;
      1: return (a - b + 32) % 32;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 15 - a;
      6: return a * 2;
      default: return a / 2;
    endcase
  endfunction

  function automatic int exp_grant();
    if (m_inflight) return -1;
    if (req_valid == 2'b11) return m_last ? 0 : 1;
    if (req_valid[0]) return 0;
    if (req_valid[1]) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_ready();
    int g;
    g = exp_grant();
    if (g < 0) return 2'b00;
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic bit exp_rsp_valid();
    return m_inflight && (m_age >= 1);
  endfunction

  task automatic model_reset();
    m_inflight = 1'b0;
    m_age = 0;
    m_last = 1'b1;
    m_count = 0;
    m_acc = -1;
    q_data.delete();
    q_id.delete();
  endtask

  task automatic model_edge();
    int g, a, b, op;
    g = exp_grant();
    m_acc = -1;
    if (!m_inflight) begin
      if (g >= 0) begin
        a  = (g == 0) ? int'(req_a[3:0])  : int'(req_a[7:4]);
        b  = (g == 0) ? int'(req_b[3:0])  : int'(req_b[7:4]);
        op = (g == 0) ? int'(req_op[2:0]) : int'(req_op[5:3]);
        q_data.push_back(alu_ref(a, b, op));
        q_id.push_back(g);
        m_inflight = 1'b1;
        m_age = 0;
        m_last = (g == 1);
        m_acc = g;
      end
    end else if (m_age >= 1 && rsp_ready) begin
      m_inflight = 1'b0;
      m_count = (m_count + 1) % (1 << CNT_W);
      void'(q_data.pop_front());
      void'(q_id.pop_front());
    end else begin
      m_age++;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    while (m_inflight && guard < 10) begin
      tick();
      guard++;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== 5'd0) begin n_err++; $display("FAIL reset_rsp_data: got %b want 00000", rsp_data); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (op_count !== '0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    rst_n = 1'b1;
    // First tie after reset goes to requester 0; valid is withdrawn before any edge.
    req_valid = 2'b11;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL reset_first_tie: got %b want 01", req_ready); end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_a[3:0] = 4'b0101; req_b[3:0] = 4'b0011; req_op[2:0] = 3'b000;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_accept: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_exec: got busy=%b vld=%b want busy=1 vld=0", busy, rsp_valid); end
    tick();
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 5'b01000 || rsp_id !== 1'b0) begin n_err++; $display("FAIL single_rsp: got data=%b id=%b want 01000 id 0", rsp_data, rsp_id); end
    rsp_ready = 1'b1;
    tick();
    #1;
    n_cmp++; if (op_count !== 8'd1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: got cnt=%0d vld=%b busy=%b want 1 0 0", op_count, rsp_valid, busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_alternate();
    int grants[$];
    req_a = {4'd5, 4'd5}; req_b = {4'd3, 4'd3}; req_op = {3'b001, 3'b000};
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_cmp++; if (req_ready !== exp_ready()) begin n_err++; $display("FAIL alt_ready: cycle %0d got %b want %b", c, req_ready, exp_ready()); end
      if (req_ready != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
      if (exp_rsp_valid()) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== q_id[0][0] || rsp_data !== (q_id[0] == 1 ? 5'b00010 : 5'b01000)) begin
          n_err++; $display("FAIL alt_rsp: got vld=%b id=%b data=%b want 1 id %0d data %0d", rsp_valid, rsp_id, rsp_data, q_id[0], q_data[0]);
        end
      end
      tick();
    end
    n_cmp++; if (grants.size() != 4) begin n_err++; $display("FAIL alt_grant_count: got %0d want 4", grants.size()); end
    for (int i = 1; i < grants.size(); i++) begin
      n_cmp++; if (grants[i] == grants[i-1]) begin n_err++; $display("FAIL alt_alternation: grant %0d got %0d want %0d", i, grants[i], 1 - grants[i-1]); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    req_a[3:0] = 4'd5; req_b[3:0] = 4'd3; req_op[2:0] = 3'b000;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    tick();
    req_a[7:4] = 4'b0101; req_b[7:4] = 4'b0011; req_op[5:3] = 3'b010;
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== 5'b01000 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
        n_err++; $display("FAIL bp_hold: cycle %0d got vld=%b data=%b id=%b rdy=%b want 1 01000 0 00", c, rsp_valid, rsp_data, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready_in_resp: got %b want 00", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_accept_req1: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 5'b00001 || rsp_id !== 1'b1) begin n_err++; $display("FAIL bp_rsp: got vld=%b data=%b id=%b want 1 00001 1", rsp_valid, rsp_data, rsp_id); end
    drain();
  endtask

  task automatic test_carry();
    req_a[3:0] = 4'b1111; req_b[3:0] = 4'b0001; req_op[2:0] = 3'b000;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    req_valid = 2'b00;
    tick();
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 5'b10000) begin n_err++; $display("FAIL carry: got vld=%b data=%b want 1 10000", rsp_valid, rsp_data); end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && m_acc != i) begin
          // Holding an unaccepted request; occasionally withdraw it.
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[4*i +: 4] = 4'($urandom);
          req_b[4*i +: 4] = 4'($urandom);
          req_op[3*i +: 3] = 3'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++; if (req_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, req_ready, exp_ready()); end
      n_cmp++; if (busy !== m_inflight || rsp_valid !== exp_rsp_valid()) begin n_err++; $display("FAIL rnd_state: cycle %0d got busy=%b vld=%b want %b %b", c, busy, rsp_valid, m_inflight, exp_rsp_valid()); end
      n_cmp++; if (int'(op_count) != m_count) begin n_err++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", c, op_count, m_count); end
      if (exp_rsp_valid()) begin
        n_cmp++;
        if (int'(rsp_data) != q_data[0] || int'(rsp_id) != q_id[0]) begin
          n_err++; $display("FAIL rnd_rsp: cycle %0d got data=%0d id=%0d want %0d id %0d", c, rsp_data, rsp_id, q_data[0], q_id[0]);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    req_a[3:0] = 4'd15; req_b[3:0] = 4'd15; req_op[2:0] = 3'b000;
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL midrst_ctrl: got busy=%b vld=%b rdy=%b want 0 0 00", busy, rsp_valid, req_ready); end
    n_cmp++; if (op_count !== '0 || rsp_data !== 5'd0 || rsp_id !== 1'b0) begin n_err++; $display("FAIL midrst_data: got cnt=%0d data=%b id=%b want 0 00000 0", op_count, rsp_data, rsp_id); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== '0) begin n_err++; $display("FAIL midrst_after: cycle %0d got vld=%b busy=%b cnt=%0d want 0 0 0", c, rsp_valid, busy, op_count); end
      tick();
    end
  endtask

  task automatic test_wrap();
    int n_rsp, cyc;
    n_rsp = 0;
    cyc = 0;
    rsp_ready = 1'b1;
    m_acc = 0;
    while (n_rsp < 256 && cyc < 1200) begin
      if (m_acc >= 0) begin
        req_valid = 2'($urandom_range(1, 3));
        req_a = 8'($urandom); req_b = 8'($urandom); req_op = 6'($urandom);
      end
      #1;
      n_cmp++; if (int'(op_count) != m_count) begin n_err++; $display("FAIL wrap_count: cycle %0d got %0d want %0d", cyc, op_count, m_count); end
      if (exp_rsp_valid()) begin
        n_cmp++;
        if (rsp_valid !== 1'b1 || int'(rsp_data) != q_data[0] || int'(rsp_id) != q_id[0]) begin
          n_err++; $display("FAIL wrap_rsp: response %0d got vld=%b data=%0d id=%0d want 1 %0d id %0d", n_rsp, rsp_valid, rsp_data, rsp_id, q_data[0], q_id[0]);
        end
        n_rsp++;
      end
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    #1;
    n_cmp++; if (n_rsp != 256) begin n_err++; $display("FAIL wrap_budget: got %0d responses want 256", n_rsp); end
    n_cmp++; if (op_count !== 8'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", op_count); end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish within time limit want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_carry();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
